hazard_ctrl: RTL

Pipeline sequencing controller for the decode stage and its neighbours.
- Detects load-use RAW hazards against the EX stage and inserts one bubble.
- Freezes the whole pipe while the data memory has not returned DM_valid.
- Kills wrong-path fetches after a redirect resolved in decode.
- Drives PC/IF-ID/ID-EX enables, flush and decode_ppload, and raises a sticky timeout if memory never answers.

---
 rtl/hazard_ctrl_if.sv | 39 +++
 rtl/hazard_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode/EX/MEM status into the hazard controller and
// pipeline enables/flush back out. master = pipeline side, slave = controller.
interface hazard_ctrl_if #(
    parameter int unsigned REG_ADDR = 5
);
    logic                id_valid;
    logic [REG_ADDR-1:0] id_rs1;
    logic [REG_ADDR-1:0] id_rs2;
    logic                id_uses_rs1;
    logic                id_uses_rs2;
    logic                ex_valid;
    logic                ex_load;
    logic [REG_ADDR-1:0] ex_rd;
    logic                mem_req;
    logic                DM_valid;
    logic                redirect;

    logic                pc_en;
    logic                if_id_en;
    logic                if_id_flush;
    logic                id_ex_en;
    logic                decode_ppload;
    logic                mem_timeout;
    logic                busy;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_valid, ex_load, ex_rd, mem_req, DM_valid, redirect,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, decode_ppload,
               mem_timeout, busy
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_valid, ex_load, ex_rd, mem_req, DM_valid, redirect,
        output pc_en, if_id_en, if_id_flush, id_ex_en, decode_ppload,
               mem_timeout, busy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage sequencing controller. Inserts load-use bubbles,
// freezes the pipe on outstanding data-memory accesses, kills wrong-path
// fetches after a redirect and halts with a sticky error if memory never
// answers. RUN-state decisions take effect in the same cycle.
// Optional: define HAZARD_PERF_CNT_EN to add 32-bit performance counters.
module hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned REG_ADDR     = 5
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]   perf_lu_stalls,
    output logic [31:0]   perf_mem_wait,
    output logic [31:0]   perf_flushes
`endif
);

    localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned FW = 3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2,
        HALT     = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [FW-1:0]   fcnt_q,  fcnt_d;
    logic            to_q,    to_d;

    logic [REG_ADDR-1:0] rs1, rs2, rd;
    logic            lu_hazard;
    logic            mem_stall;

    logic            pc_en, if_id_en, id_ex_en, if_id_flush, decode_ppload;
    logic            lu_bubble, redir_acc, wait_stall;

    // Load-use RAW against EX; x0 is never a real dependency
    assign rs1 = bus.id_rs1;
    assign rs2 = bus.id_rs2;
    assign rd  = bus.ex_rd;
    assign lu_hazard = bus.id_valid & bus.ex_valid & bus.ex_load & (rd != '0) &
                       ((bus.id_uses_rs1 & (rs1 == rd)) |
                        (bus.id_uses_rs2 & (rs2 == rd)));
    assign mem_stall = bus.mem_req & ~bus.DM_valid;

    // State, wait timer, flush counter and sticky timeout registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            timer_q <= '0;
            fcnt_q  <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            fcnt_q  <= fcnt_d;
            to_q    <= to_d;
        end
    end

    // Next-state and pipeline control decode
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        fcnt_d        = fcnt_q;
        to_d          = to_q;
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        if_id_flush   = 1'b0;
        decode_ppload = 1'b0;
        lu_bubble     = 1'b0;
        redir_acc     = 1'b0;
        wait_stall    = 1'b0;

        if (rst) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            if_id_flush   = 1'b1;
            decode_ppload = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_stall) begin
                        pc_en    = 1'b0;
                        if_id_en = 1'b0;
                        id_ex_en = 1'b0;
                        state_d  = MEM_WAIT;
                        timer_d  = TW'(1);
                    end else if (lu_hazard) begin
                        // Hold fetch/decode, push one bubble; a redirect in
                        // decode is re-evaluated once the load has moved on
                        pc_en         = 1'b0;
                        if_id_en      = 1'b0;
                        decode_ppload = 1'b1;
                        lu_bubble     = 1'b1;
                    end else if (bus.redirect & bus.id_valid) begin
                        if_id_flush = 1'b1;
                        redir_acc   = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = FLUSH;
                            fcnt_d  = FW'(FLUSH_CYCLES - 1);
                        end
                    end
                end
                MEM_WAIT: begin
                    if (!bus.DM_valid) begin
                        pc_en      = 1'b0;
                        if_id_en   = 1'b0;
                        id_ex_en   = 1'b0;
                        wait_stall = 1'b1;
                        if (timer_q == TW'(MEM_TIMEOUT)) begin
                            state_d = HALT;
                            to_d    = 1'b1;
                        end else begin
                            timer_d = timer_q + TW'(1);
                        end
                    end else begin
                        state_d = RUN;
                    end
                end
                FLUSH: begin
                    if (mem_stall) begin
                        // Memory stall wins; remaining flush count is dropped
                        pc_en    = 1'b0;
                        if_id_en = 1'b0;
                        id_ex_en = 1'b0;
                        state_d  = MEM_WAIT;
                        timer_d  = TW'(1);
                        fcnt_d   = '0;
                    end else begin
                        if_id_flush   = 1'b1;
                        decode_ppload = 1'b1;
                        if (fcnt_q <= FW'(1)) begin
                            state_d = RUN;
                            fcnt_d  = '0;
                        end else begin
                            fcnt_d = fcnt_q - FW'(1);
                        end
                    end
                end
                HALT: begin
                    pc_en    = 1'b0;
                    if_id_en = 1'b0;
                    id_ex_en = 1'b0;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // Drive the interface outputs
    assign bus.pc_en         = pc_en;
    assign bus.if_id_en      = if_id_en;
    assign bus.id_ex_en      = id_ex_en;
    assign bus.if_id_flush   = if_id_flush;
    assign bus.decode_ppload = decode_ppload;
    assign bus.mem_timeout   = to_q & ~rst;
    assign bus.busy          = (state_q != RUN) & ~rst;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_lu_q, perf_mw_q, perf_fl_q;

    // Free-running event counters, wrap at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lu_q <= '0;
            perf_mw_q <= '0;
            perf_fl_q <= '0;
        end else begin
            if (lu_bubble)  perf_lu_q <= perf_lu_q + 32'd1;
            if (wait_stall) perf_mw_q <= perf_mw_q + 32'd1;
            if (redir_acc)  perf_fl_q <= perf_fl_q + 32'd1;
        end
    end

    assign perf_lu_stalls = perf_lu_q;
    assign perf_mem_wait  = perf_mw_q;
    assign perf_flushes   = perf_fl_q;
`else
    logic unused_perf;
    assign unused_perf = lu_bubble ^ redir_acc ^ wait_stall;
`endif

endmodule
